// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encodings, default sizes, address helpers.
package mem_access_stage_pkg;

  localparam int DATA_W_DEFAULT  = 32;
  localparam int TIMEOUT_DEFAULT = 64;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_access_stage_memwb_reg.sv
// MEM/WB pipeline register; a bubble clears every field so nothing is written back.
module mem_access_stage_memwb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_bubble,
  input  logic              i_regwrite,
  input  logic              i_memtoreg,
  input  logic [DATA_W-1:0] i_alures,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic [4:0]        i_dest,
  output logic              o_regwrite,
  output logic              o_memtoreg,
  output logic [DATA_W-1:0] o_alures,
  output logic [DATA_W-1:0] o_rddata,
  output logic [4:0]        o_dest
);

  always_ff @(posedge clk_i) begin
    if (rst_i || i_bubble) begin
      o_regwrite <= 1'b0;
      o_memtoreg <= 1'b0;
      o_alures   <= '0;
      o_rddata   <= '0;
      o_dest     <= '0;
    end else begin
      o_regwrite <= i_regwrite;
      o_memtoreg <= i_memtoreg;
      o_alures   <= i_alures;
      o_rddata   <= i_rddata;
      o_dest     <= i_dest;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a req/ack bus with stall, misalignment and timeout reporting.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] ALUres_i,
  input  logic [DATA_W-1:0] wrdata_i,
  input  logic [4:0]        WriteBackPath_i,
  output logic              stall_o,
  mem_access_stage_if.master mem_if,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ALUres_o,
  output logic [DATA_W-1:0] rddata_o,
  output logic [4:0]        WriteBackPath_o,
  output logic              misalign_o,
  output logic              timeout_o
);

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_counter;
  logic              r_we;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_dest;
  logic              r_misalign;
  logic              r_timeout;

  logic              w_access;
  logic              w_misaligned;
  logic              w_idle;
  logic              w_wait;
  logic              w_start;
  logic              w_ack;
  logic              w_expire;
  logic              w_bubble;
  logic              w_wb_regwrite;
  logic              w_wb_memtoreg;
  logic [DATA_W-1:0] w_wb_alures;
  logic [DATA_W-1:0] w_wb_rddata;
  logic [4:0]        w_wb_dest;

  assign w_access     = MemRead_i | MemWrite_i;
  assign w_misaligned = is_misaligned(ALUres_i[1:0]);
  assign w_idle       = (r_state == ST_IDLE);
  assign w_wait       = (r_state == ST_WAIT);
  assign w_start      = w_idle & w_access & ~w_misaligned;
  assign w_ack        = w_wait & mem_if.mem_ack_i;
  // An ack arriving in the final counted cycle takes priority over the abort.
  assign w_expire     = w_wait & ~mem_if.mem_ack_i & (r_counter == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_counter  <= '0;
      r_we       <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dest     <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_misalign <= w_idle & w_access & w_misaligned;
      r_timeout  <= w_expire;
      if (w_start) begin
        r_state    <= ST_WAIT;
        r_counter  <= '0;
        r_we       <= MemWrite_i;
        r_regwrite <= RegWrite_i;
        r_memtoreg <= MemtoReg_i;
        r_addr     <= ALUres_i;
        r_wdata    <= wrdata_i;
        r_dest     <= WriteBackPath_i;
      end else if (w_ack || w_expire) begin
        r_state   <= ST_IDLE;
        r_counter <= '0;
      end else if (w_wait) begin
        r_counter <= r_counter + CNT_W'(1);
      end
    end
  end

  assign mem_if.mem_req_o   = w_wait;
  assign mem_if.mem_we_o    = r_we;
  assign mem_if.mem_addr_o  = r_addr;
  assign mem_if.mem_wdata_o = r_wdata;

  assign stall_o    = w_start | (w_wait & ~mem_if.mem_ack_i);
  assign misalign_o = r_misalign;
  assign timeout_o  = r_timeout;

  // Only a plain ALU op in IDLE or a completing access reaches MEM/WB; everything else is a bubble.
  assign w_bubble      = ~((w_idle & ~w_access) | w_ack);
  assign w_wb_regwrite = w_wait ? r_regwrite : RegWrite_i;
  assign w_wb_memtoreg = w_wait ? r_memtoreg : MemtoReg_i;
  assign w_wb_alures   = w_wait ? r_addr : ALUres_i;
  assign w_wb_dest     = w_wait ? r_dest : WriteBackPath_i;
  assign w_wb_rddata   = (w_wait && !r_we) ? mem_if.mem_rdata_i : '0;

  mem_access_stage_memwb_reg #(
    .DATA_W(DATA_W)
  ) u_memwb_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_bubble   (w_bubble),
    .i_regwrite (w_wb_regwrite),
    .i_memtoreg (w_wb_memtoreg),
    .i_alures   (w_wb_alures),
    .i_rddata   (w_wb_rddata),
    .i_dest     (w_wb_dest),
    .o_regwrite (RegWrite_o),
    .o_memtoreg (MemtoReg_o),
    .o_alures   (ALUres_o),
    .o_rddata   (rddata_o),
    .o_dest     (WriteBackPath_o)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=8 and a hand-driven memory slave.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] alu_res;
  logic [31:0] wr_data;
  logic [4:0]  wb_path;
  logic        stall;
  logic        regwrite_out;
  logic        memtoreg_out;
  logic [31:0] alures_out;
  logic [31:0] rddata_out;
  logic [4:0]  wbpath_out;
  logic        misalign;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if #(.DATA_W(32)) mem_if ();

  mem_access_stage #(
    .DATA_W  (32),
    .TIMEOUT (8),
    .CNT_W   (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .MemRead_i       (mem_read),
    .MemWrite_i      (mem_write),
    .RegWrite_i      (reg_write),
    .MemtoReg_i      (mem_to_reg),
    .ALUres_i        (alu_res),
    .wrdata_i        (wr_data),
    .WriteBackPath_i (wb_path),
    .stall_o         (stall),
    .mem_if          (mem_if),
    .RegWrite_o      (regwrite_out),
    .MemtoReg_o      (memtoreg_out),
    .ALUres_o        (alures_out),
    .rddata_o        (rddata_out),
    .WriteBackPath_o (wbpath_out),
    .misalign_o      (misalign),
    .timeout_o       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dst);
    mem_read   = mr;
    mem_write  = mw;
    reg_write  = rw;
    mem_to_reg = m2r;
    alu_res    = alu;
    wr_data    = wd;
    wb_path    = dst;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_regwrite"}, {31'd0, regwrite_out}, 32'd0);
    chk({tag, "_memtoreg"}, {31'd0, memtoreg_out}, 32'd0);
    chk({tag, "_alures"}, alures_out, 32'd0);
    chk({tag, "_rddata"}, rddata_out, 32'd0);
    chk({tag, "_wbpath"}, {27'd0, wbpath_out}, 32'd0);
    chk({tag, "_req"}, {31'd0, mem_if.mem_req_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_if.mem_we_o}, 32'd0);
    chk({tag, "_addr"}, mem_if.mem_addr_o, 32'd0);
    chk({tag, "_wdata"}, mem_if.mem_wdata_o, 32'd0);
    chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = 32'h0;
    cyc();
    cyc();
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: plain ALU op passes through with one cycle of latency
    drive(0, 0, 1, 0, 32'h1234, 32'h0, 5'd5);
    #1;
    chk("alu_stall", {31'd0, stall}, 32'd0);
    cyc();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1;
    $display("txn alu: regwrite=%0b alures=%h dest=%0d", regwrite_out, alures_out, wbpath_out);
    chk("alu_regwrite", {31'd0, regwrite_out}, 32'd1);
    chk("alu_alures", alures_out, 32'h1234);
    chk("alu_dest", {27'd0, wbpath_out}, 32'd5);
    chk("alu_rddata", rddata_out, 32'd0);
    chk("alu_stall2", {31'd0, stall}, 32'd0);

    // 2: aligned load, ack on the third WAIT cycle
    drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd7);
    #1;
    chk("ld_stall_idle", {31'd0, stall}, 32'd1);
    chk("ld_req_idle", {31'd0, mem_if.mem_req_o}, 32'd0);
    cyc();
    #1;
    chk("ld_w1_req", {31'd0, mem_if.mem_req_o}, 32'd1);
    chk("ld_w1_addr", mem_if.mem_addr_o, 32'h100);
    chk("ld_w1_we", {31'd0, mem_if.mem_we_o}, 32'd0);
    chk("ld_w1_stall", {31'd0, stall}, 32'd1);
    chk("ld_w1_bubble", {31'd0, regwrite_out}, 32'd0);
    cyc();
    #1;
    chk("ld_w2_req", {31'd0, mem_if.mem_req_o}, 32'd1);
    chk("ld_w2_stall", {31'd0, stall}, 32'd1);
    cyc();
    mem_if.mem_ack_i   = 1'b1;
    mem_if.mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("ld_w3_req", {31'd0, mem_if.mem_req_o}, 32'd1);
    chk("ld_w3_stall", {31'd0, stall}, 32'd0);
    cyc();
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = 32'h0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1;
    $display("txn load: rddata=%h regwrite=%0b dest=%0d", rddata_out, regwrite_out, wbpath_out);
    chk("ld_rddata", rddata_out, 32'hDEADBEEF);
    chk("ld_regwrite", {31'd0, regwrite_out}, 32'd1);
    chk("ld_memtoreg", {31'd0, memtoreg_out}, 32'd1);
    chk("ld_alures", alures_out, 32'h100);
    chk("ld_dest", {27'd0, wbpath_out}, 32'd7);
    chk("ld_req_done", {31'd0, mem_if.mem_req_o}, 32'd0);

    // 3: store acked on the first WAIT cycle
    drive(0, 1, 0, 0, 32'h40, 32'hA5A5A5A5, 5'd0);
    #1;
    chk("st_stall_idle", {31'd0, stall}, 32'd1);
    cyc();
    mem_if.mem_ack_i = 1'b1;
    #1;
    chk("st_we", {31'd0, mem_if.mem_we_o}, 32'd1);
    chk("st_wdata", mem_if.mem_wdata_o, 32'hA5A5A5A5);
    chk("st_addr", mem_if.mem_addr_o, 32'h40);
    chk("st_stall_ack", {31'd0, stall}, 32'd0);
    cyc();
    mem_if.mem_ack_i = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1;
    $display("txn store: regwrite=%0b rddata=%h alures=%h", regwrite_out, rddata_out, alures_out);
    chk("st_regwrite", {31'd0, regwrite_out}, 32'd0);
    chk("st_rddata", rddata_out, 32'd0);
    chk("st_alures", alures_out, 32'h40);
    chk("st_stall_after", {31'd0, stall}, 32'd0);

    // 4: misaligned load produces a bubble and a misalign pulse
    drive(1, 0, 1, 1, 32'h102, 32'h0, 5'd9);
    #1;
    chk("mis_stall", {31'd0, stall}, 32'd0);
    cyc();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1;
    $display("txn misalign: misalign=%0b req=%0b regwrite=%0b", misalign, mem_if.mem_req_o, regwrite_out);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_req", {31'd0, mem_if.mem_req_o}, 32'd0);
    chk("mis_regwrite", {31'd0, regwrite_out}, 32'd0);
    cyc();
    #1;
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);

    // 5: load never acknowledged aborts after 8 WAIT cycles
    drive(1, 0, 1, 1, 32'h200, 32'h0, 5'd3);
    #1;
    chk("to_stall_idle", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      #1;
      chk($sformatf("to_w%0d_req", i + 1), {31'd0, mem_if.mem_req_o}, 32'd1);
      chk($sformatf("to_w%0d_stall", i + 1), {31'd0, stall}, 32'd1);
      chk($sformatf("to_w%0d_timeout", i + 1), {31'd0, timeout}, 32'd0);
    end
    cyc();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1;
    $display("txn timeout: timeout=%0b stall=%0b req=%0b", timeout, stall, mem_if.mem_req_o);
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_stall", {31'd0, stall}, 32'd0);
    chk("to_req", {31'd0, mem_if.mem_req_o}, 32'd0);
    chk("to_regwrite", {31'd0, regwrite_out}, 32'd0);
    mem_if.mem_ack_i   = 1'b1;
    mem_if.mem_rdata_i = 32'h55555555;
    cyc();
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = 32'h0;
    #1;
    chk("stray_timeout", {31'd0, timeout}, 32'd0);
    chk("stray_rddata", rddata_out, 32'd0);
    chk("stray_req", {31'd0, mem_if.mem_req_o}, 32'd0);
    chk("stray_stall", {31'd0, stall}, 32'd0);

    // 6: reset in the second WAIT cycle discards the transaction
    drive(1, 0, 1, 1, 32'h300, 32'h0, 5'd4);
    cyc();
    cyc();
    #1;
    chk("rw_w2_req", {31'd0, mem_if.mem_req_o}, 32'd1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    cyc();
    #1;
    $display("txn reset_mid_wait: req=%0b addr=%h", mem_if.mem_req_o, mem_if.mem_addr_o);
    chk_all_zero("rw");
    rst = 1'b0;
    cyc();
    #1;
    chk("rw_after_req", {31'd0, mem_if.mem_req_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
